opb_simulink_master: RTL and testbench

- Single-transfer OPB bus master for the ROACH user fabric.
- Lets user logic initiate 32-bit reads and writes to OPB slaves, such as the simulink/PPC register bridges, without involving the PPC.
- User side is a command/response handshake. Bus side drives the OPB master signals and handles acknowledge, error, retry and timeout.
- Sits between a user-logic sequencer and the OPB arbiter/bus.

---
 rtl/opb_simulink_master.sv | 209 ++++++++++++++++++++
 tb/tb_opb_simulink_master.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_simulink_master.sv
// Single-transfer OPB bus master: a user command/response handshake on one side,
// OPB request/select with ack, error, retry and timeout handling on the other.
module opb_simulink_master #(
    parameter int unsigned C_OPB_AWIDTH  = 32,
    parameter int unsigned C_OPB_DWIDTH  = 32,
    parameter int unsigned C_TOUT_CYCLES = 16,
    parameter int unsigned C_MAX_RETRY   = 3
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_rnw,
    input  logic [C_OPB_AWIDTH-1:0]     cmd_addr,
    input  logic [C_OPB_DWIDTH-1:0]     cmd_wdata,
    input  logic [C_OPB_DWIDTH/8-1:0]   cmd_be,
    output logic                        rsp_valid,
    output logic [C_OPB_DWIDTH-1:0]     rsp_rdata,
    output logic [1:0]                  rsp_status,
    output logic                        M_request,
    input  logic                        OPB_MGrant,
    output logic                        M_select,
    output logic                        M_RNW,
    output logic [0:C_OPB_AWIDTH-1]     M_ABus,
    output logic [0:C_OPB_DWIDTH/8-1]   M_BE,
    output logic [0:C_OPB_DWIDTH-1]     M_DBus,
    output logic                        M_seqAddr,
    output logic                        M_busLock,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_xferAck,
    input  logic                        OPB_errAck,
    input  logic                        OPB_retry,
    input  logic                        OPB_toutSup
);

    localparam int unsigned AW     = C_OPB_AWIDTH;
    localparam int unsigned DW     = C_OPB_DWIDTH;
    localparam int unsigned BEW    = C_OPB_DWIDTH / 8;
    localparam int unsigned TCNT_W = $clog2(C_TOUT_CYCLES + 1);
    localparam int unsigned RCNT_W = $clog2(C_MAX_RETRY + 1);

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_ERR   = 2'b01;
    localparam logic [1:0] ST_TOUT  = 2'b10;
    localparam logic [1:0] ST_RETRY = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_BACKOFF,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_handshake;
    logic                w_retry_inc;
    logic                w_capture;
    logic [1:0]          w_status;
    logic                w_xfer_next;

    logic                r_rnw;
    logic [AW-1:0]       r_addr;
    logic [DW-1:0]       r_wdata;
    logic [BEW-1:0]      r_be;
    logic [RCNT_W-1:0]   r_retry_cnt;
    logic [TCNT_W-1:0]   r_tout_cnt;
    logic [DW-1:0]       r_rdata;
    logic [1:0]          r_status;

    logic                r_cmd_ready;
    logic                r_rsp_valid;
    logic                r_m_request;
    logic                r_m_select;
    logic                r_m_rnw;
    logic [AW-1:0]       r_m_abus;
    logic [BEW-1:0]      r_m_be;
    logic [DW-1:0]       r_m_dbus;

    // Next-state and response decode; XFER resolves retry > errAck > xferAck > timeout.
    always_comb begin
        w_next      = r_state;
        w_handshake = 1'b0;
        w_retry_inc = 1'b0;
        w_capture   = 1'b0;
        w_status    = r_status;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_handshake = 1'b1;
                    w_next      = S_REQ;
                end
            end
            S_REQ: begin
                if (OPB_MGrant) begin
                    w_next = S_XFER;
                end
            end
            S_XFER: begin
                if (OPB_retry) begin
                    if (r_retry_cnt < RCNT_W'(C_MAX_RETRY)) begin
                        w_retry_inc = 1'b1;
                        w_next      = S_BACKOFF;
                    end else begin
                        w_status = ST_RETRY;
                        w_next   = S_DONE;
                    end
                end else if (OPB_errAck) begin
                    w_status = ST_ERR;
                    w_next   = S_DONE;
                end else if (OPB_xferAck) begin
                    w_capture = r_rnw;
                    w_status  = ST_OK;
                    w_next    = S_DONE;
                end else if (r_tout_cnt == TCNT_W'(C_TOUT_CYCLES - 1)) begin
                    w_status = ST_TOUT;
                    w_next   = S_DONE;
                end
            end
            S_BACKOFF: w_next = S_REQ;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    assign w_xfer_next = (w_next == S_XFER);

    // State register.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Command, counters and response registers.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_rnw       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_retry_cnt <= '0;
            r_tout_cnt  <= '0;
            r_rdata     <= '0;
            r_status    <= ST_OK;
        end else begin
            if (w_handshake) begin
                r_rnw       <= cmd_rnw;
                r_addr      <= cmd_addr;
                r_wdata     <= cmd_wdata;
                r_be        <= cmd_be;
                r_retry_cnt <= '0;
            end else if (w_retry_inc) begin
                r_retry_cnt <= r_retry_cnt + RCNT_W'(1);
            end
            // Held at zero outside XFER so every select phase starts counting from 0.
            if (r_state != S_XFER) begin
                r_tout_cnt <= '0;
            end else if (!OPB_toutSup) begin
                r_tout_cnt <= r_tout_cnt + TCNT_W'(1);
            end
            if (w_capture) begin
                r_rdata <= OPB_DBus;
            end
            r_status <= w_status;
        end
    end

    // Registered outputs decoded from the next state; bus fields are zero unless selected.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_m_request <= 1'b0;
            r_m_select  <= 1'b0;
            r_m_rnw     <= 1'b0;
            r_m_abus    <= '0;
            r_m_be      <= '0;
            r_m_dbus    <= '0;
        end else begin
            r_cmd_ready <= (w_next == S_IDLE);
            r_rsp_valid <= (w_next == S_DONE);
            r_m_request <= (w_next == S_REQ);
            r_m_select  <= w_xfer_next;
            r_m_rnw     <= w_xfer_next && r_rnw;
            r_m_abus    <= w_xfer_next ? r_addr : '0;
            r_m_be      <= w_xfer_next ? r_be : '0;
            r_m_dbus    <= (w_xfer_next && !r_rnw) ? r_wdata : '0;
        end
    end

    // Positional assignment onto the ascending OPB ranges gives user bit N-1-i -> OPB bit i.
    assign cmd_ready  = r_cmd_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rdata;
    assign rsp_status = r_status;
    assign M_request  = r_m_request;
    assign M_select   = r_m_select;
    assign M_RNW      = r_m_rnw;
    assign M_ABus     = r_m_abus;
    assign M_BE       = r_m_be;
    assign M_DBus     = r_m_dbus;
    assign M_seqAddr  = 1'b0;
    assign M_busLock  = 1'b0;

endmodule

// File: tb/tb_opb_simulink_master.sv
// Self-checking bench for opb_simulink_master: arbiter/slave model driven per transfer,
// expected responses queued at command time and compared when rsp_valid fires.
module tb_opb_simulink_master;

    localparam int MAX_RETRY = 3;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst = 1'b1;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rnw;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        M_request;
    logic        OPB_MGrant;
    logic        M_select;
    logic        M_RNW;
    logic [0:31] M_ABus;
    logic [0:3]  M_BE;
    logic [0:31] M_DBus;
    logic        M_seqAddr;
    logic        M_busLock;
    logic [0:31] OPB_DBus;
    logic        OPB_xferAck;
    logic        OPB_errAck;
    logic        OPB_retry;
    logic        OPB_toutSup;

    opb_simulink_master dut (
        .OPB_Clk     (OPB_Clk),
        .OPB_Rst     (OPB_Rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rnw     (cmd_rnw),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_be      (cmd_be),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_status  (rsp_status),
        .M_request   (M_request),
        .OPB_MGrant  (OPB_MGrant),
        .M_select    (M_select),
        .M_RNW       (M_RNW),
        .M_ABus      (M_ABus),
        .M_BE        (M_BE),
        .M_DBus      (M_DBus),
        .M_seqAddr   (M_seqAddr),
        .M_busLock   (M_busLock),
        .OPB_DBus    (OPB_DBus),
        .OPB_xferAck (OPB_xferAck),
        .OPB_errAck  (OPB_errAck),
        .OPB_retry   (OPB_retry),
        .OPB_toutSup (OPB_toutSup)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rdata = 32'h0;

    // Per-transfer arbiter/slave behaviour, set by the stimulus before each command.
    int          gnt_dly    = 0;
    int          n_retry    = 0;
    logic        retry_ack  = 1'b0;
    int          ack_at     = 1;
    logic        err_flag   = 1'b0;
    int          sup_cycles = 0;
    logic [31:0] slave_rdata = 32'h0;

    // Observations accumulated by the bus model.
    int          req_cnt   = 0;
    int          sel_cnt   = 0;
    int          attempt   = 0;
    int          last_len  = 0;
    int          n_bursts  = 0;
    int          n_backoff = 0;
    int          n_viol    = 0;
    int          n_rsp     = 0;
    logic        prev_sel  = 1'b0;
    logic [31:0] cap_abus  = 32'h0;
    logic [31:0] cap_dbus  = 32'h0;
    logic [3:0]  cap_be    = 4'h0;
    logic        cap_rnw   = 1'b0;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Arbiter + slave model: observe outputs, then drive inputs, on each falling edge.
    initial begin
        OPB_MGrant  = 1'b0;
        OPB_DBus    = 32'h0;
        OPB_xferAck = 1'b0;
        OPB_errAck  = 1'b0;
        OPB_retry   = 1'b0;
        OPB_toutSup = 1'b0;
        forever begin
            @(negedge OPB_Clk);
            if (!M_select && (M_ABus != 32'h0 || M_BE != 4'h0 || M_DBus != 32'h0 || M_RNW))
                n_viol++;
            if (M_select && M_RNW && M_DBus != 32'h0)
                n_viol++;
            if (M_seqAddr || M_busLock)
                n_viol++;
            if (rsp_valid)
                n_rsp++;
            if (prev_sel && !M_select && !M_request && !rsp_valid)
                n_backoff++;
            if (M_select && !prev_sel)
                n_bursts++;
            if (cmd_ready)
                attempt = 0;
            if (M_select) begin
                sel_cnt++;
                if (sel_cnt == 1 && attempt == 0) begin
                    cap_abus = M_ABus;
                    cap_dbus = M_DBus;
                    cap_be   = M_BE;
                    cap_rnw  = M_RNW;
                end
            end else begin
                if (prev_sel) begin
                    last_len = sel_cnt;
                    attempt++;
                end
                sel_cnt = 0;
            end
            prev_sel = M_select;

            OPB_MGrant  = 1'b0;
            OPB_DBus    = 32'h0;
            OPB_xferAck = 1'b0;
            OPB_errAck  = 1'b0;
            OPB_retry   = 1'b0;
            OPB_toutSup = 1'b0;
            if (M_request) req_cnt++;
            else req_cnt = 0;
            OPB_MGrant = M_request && (req_cnt > gnt_dly);
            if (M_select) begin
                if (attempt < n_retry) begin
                    if (sel_cnt == 1) begin
                        OPB_retry   = 1'b1;
                        OPB_xferAck = retry_ack;
                    end
                end else begin
                    OPB_toutSup = (sel_cnt <= sup_cycles);
                    if (sel_cnt == ack_at) begin
                        OPB_xferAck = 1'b1;
                        OPB_errAck  = err_flag;
                        OPB_DBus    = slave_rdata;
                    end
                end
            end
        end
    end

    task automatic do_txn(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int gdly, input int nret, input logic rack,
                          input int ackat, input logic err, input int sup,
                          input logic [31:0] rdat, input logic [1:0] exp_st, output int lat);
        int   bursts0, back0, viol0, rsp0, k, nr;
        bit   seen;
        exp_t e;
        gnt_dly     = gdly;
        n_retry     = nret;
        retry_ack   = rack;
        ack_at      = ackat;
        err_flag    = err;
        sup_cycles  = sup;
        slave_rdata = rdat;
        if (rnw && exp_st == 2'b00) exp_rdata = rdat;
        e.st = exp_st;
        e.rd = exp_rdata;
        sb.push_back(e);
        bursts0 = n_bursts;
        back0   = n_backoff;
        viol0   = n_viol;
        rsp0    = n_rsp;
        nr      = (nret > MAX_RETRY) ? MAX_RETRY : nret;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge OPB_Clk);
            k++;
        end
        chk("cmd_ready", 96'(cmd_ready), 96'(1));
        cmd_valid = 1'b1;
        cmd_rnw   = rnw;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_be    = be;
        @(posedge OPB_Clk);
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge OPB_Clk);
            if (i == 0) begin
                cmd_valid = 1'b0;
                cmd_addr  = 32'h0;
                cmd_wdata = 32'h0;
                cmd_be    = 4'h0;
            end
            if (rsp_valid) begin
                seen = 1'b1;
                lat  = i + 2;
            end
        end
        chk("rsp_seen", 96'(seen), 96'(1));
        if (sb.size() > 0) e = sb.pop_front();
        chk("rsp_status", 96'(rsp_status), 96'(e.st));
        chk("rsp_rdata", 96'(rsp_rdata), 96'(e.rd));
        repeat (3) @(negedge OPB_Clk);
        chk("rsp_pulses", 96'(n_rsp - rsp0), 96'(1));
        chk("rdata_hold", 96'(rsp_rdata), 96'(e.rd));
        chk("bus_idle", 96'({rsp_valid, M_request, M_select, M_RNW, M_ABus, M_BE, M_DBus}), 96'(0));
        chk("orbus_viol", 96'(n_viol - viol0), 96'(0));
        chk("bursts", 96'(n_bursts - bursts0), 96'(nr + 1));
        chk("backoffs", 96'(n_backoff - back0), 96'(nr));
    endtask

    initial begin
        int lat;
        int k;
        int rsp0;
        cmd_valid = 1'b0;
        cmd_rnw   = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        cmd_be    = 4'h0;
        #1;
        chk("rst_cmd_ready", 96'(cmd_ready), 96'(0));
        chk("rst_outputs", 96'({rsp_valid, rsp_status, rsp_rdata, M_request, M_select, M_RNW, M_BE}), 96'(0));
        repeat (3) @(negedge OPB_Clk);
        OPB_Rst = 1'b0;
        @(posedge OPB_Clk);
        #1;
        chk("cmd_ready_post_rst", 96'(cmd_ready), 96'(1));

        // Write, grant after 2 cycles, ack on first select cycle.
        do_txn(1'b0, 32'h01000900, 32'hDEADBEEF, 4'hF, 2, 0, 1'b0, 1, 1'b0, 0, 32'h0, 2'b00, lat);
        chk("wr_abus", 96'(cap_abus), 96'(32'h01000900));
        chk("wr_dbus", 96'(cap_dbus), 96'(32'hDEADBEEF));
        chk("wr_be", 96'(cap_be), 96'(4'hF));
        chk("wr_rnw", 96'(cap_rnw), 96'(0));

        // Read, ack on third select cycle.
        do_txn(1'b1, 32'h00000104, 32'hFFFFFFFF, 4'h3, 1, 0, 1'b0, 3, 1'b0, 0, 32'h12345678, 2'b00, lat);
        chk("rd_abus", 96'(cap_abus), 96'(32'h00000104));
        chk("rd_be", 96'(cap_be), 96'(4'h3));
        chk("rd_rnw", 96'(cap_rnw), 96'(1));
        chk("rd_dbus_zero", 96'(cap_dbus), 96'(0));

        // No acknowledge: aborted after 16 select cycles.
        do_txn(1'b0, 32'h00000200, 32'h11111111, 4'hF, 0, 0, 1'b0, 0, 1'b0, 0, 32'h0, 2'b10, lat);
        chk("tout_len", 96'(last_len), 96'(16));

        // Timeout suppressed for 40 cycles, then ack.
        do_txn(1'b1, 32'h00000300, 32'h0, 4'hF, 0, 0, 1'b0, 41, 1'b0, 40, 32'h0A0B0C0D, 2'b00, lat);
        chk("toutsup_len", 96'(last_len), 96'(41));

        // Three retries then ack; then four retries exhausts.
        do_txn(1'b1, 32'h00000400, 32'h0, 4'hF, 1, 3, 1'b0, 1, 1'b0, 0, 32'hCAFEF00D, 2'b00, lat);
        do_txn(1'b0, 32'h00000500, 32'h22222222, 4'hC, 0, 4, 1'b0, 1, 1'b0, 0, 32'h0, 2'b11, lat);

        // errAck with xferAck wins as error; read data not captured.
        do_txn(1'b1, 32'h00000600, 32'h0, 4'hF, 0, 0, 1'b0, 2, 1'b1, 0, 32'h55AA55AA, 2'b01, lat);

        // Retry together with xferAck still backs off.
        do_txn(1'b0, 32'h00000700, 32'h33333333, 4'h1, 0, 1, 1'b1, 1, 1'b0, 0, 32'h0, 2'b00, lat);

        // Fastest path: grant and ack immediately.
        do_txn(1'b0, 32'h00000800, 32'h44444444, 4'hF, 0, 0, 1'b0, 1, 1'b0, 0, 32'h0, 2'b00, lat);
        chk("min_latency", 96'(lat), 96'(4));

        // Reset while selected: drop at once, no response, ready right after release.
        gnt_dly    = 0;
        n_retry    = 0;
        ack_at     = 0;
        err_flag   = 1'b0;
        sup_cycles = 100000;
        cmd_valid  = 1'b1;
        cmd_rnw    = 1'b1;
        cmd_addr   = 32'h00000900;
        cmd_be     = 4'hF;
        @(posedge OPB_Clk);
        @(negedge OPB_Clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!M_select && k < 50) begin
            @(negedge OPB_Clk);
            k++;
        end
        chk("rst_test_selected", 96'(M_select), 96'(1));
        repeat (2) @(negedge OPB_Clk);
        rsp0 = n_rsp;
        OPB_Rst = 1'b1;
        #1;
        chk("rst_mid_select", 96'(M_select), 96'(0));
        chk("rst_mid_request", 96'(M_request), 96'(0));
        chk("rst_mid_rsp", 96'(rsp_valid), 96'(0));
        repeat (2) @(negedge OPB_Clk);
        OPB_Rst = 1'b0;
        @(posedge OPB_Clk);
        #1;
        chk("rst_mid_ready", 96'(cmd_ready), 96'(1));
        repeat (3) @(negedge OPB_Clk);
        chk("rst_mid_no_rsp", 96'(n_rsp - rsp0), 96'(0));
        exp_rdata = 32'h0;

        // Recovery after reset.
        do_txn(1'b0, 32'h00000A00, 32'h55555555, 4'hF, 0, 0, 1'b0, 1, 1'b0, 0, 32'h0, 2'b00, lat);
        chk("sb_empty", 96'(sb.size()), 96'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
